rpi_nibble_tx: RTL and testbench
================================

// Module: rpi_nibble_tx
// PURPOSE
//  FPGA->Raspberry Pi return path: sends bytes to the Pi as two 4-bit nibbles on GPIO.
//  Uses a 4-phase strobe/ack handshake: FPGA drives out_strobe, Pi answers on in_ack.
//  Complements the existing Pi->FPGA nibble input path. Sits in the top level next to seg/LED logic.
//  Fabric side uses a valid/ready byte interface.
// PARAMETERS
//  SETUP_CYCLES    4     clocks out_nib is held stable before out_strobe rises (>=1)
//  TIMEOUT_CYCLES  1000  max clocks waiting for an ack edge before abort (>=2)
//  MSB_FIRST       1     1: send high nibble first; 0: send low nibble first
// PORTS
//  in_clk       in   1  system clock
//  in_rst       in   1  asynchronous, active-high reset
//  in_data      in   8  byte to send; sampled on acceptance
//  in_valid     in   1  in_data valid; producer holds it until accepted
//  out_ready    out  1  block can accept a byte
//  in_ack       in   1  Pi acknowledge, asynchronous to in_clk
//  out_nib      out  4  nibble driven to the Pi
//  out_strobe   out  1  nibble-valid strobe to the Pi
//  out_busy     out  1  transfer in progress (state != IDLE)
//  out_timeout  out  1  sticky: last transfer aborted on timeout
// BEHAVIOUR
//  - All outputs are registered. During reset: out_nib=0, out_strobe=0, out_ready=0, out_busy=0, out_timeout=0.
//  - in_ack passes through a 2-FF synchronizer (reset 0) to give ack_s. All decisions use ack_s only.
//  - Accept: on the edge where in_valid && out_ready, latch in_data, clear out_ready and out_timeout, go to SETUP(first).
//  - out_ready is registered. It is set in IDLE one clock after ack_s==0 is seen.
//    It stays 0 while ack_s==1, so a stuck Pi blocks new bytes.
//  - States, with nibble index k in {0,1}:
//    IDLE: waits for an accepted byte.
//    SETUP: drive out_nib=nibble k, out_strobe=0, for SETUP_CYCLES clocks, then go to STROBE.
//    STROBE: out_strobe=1. Wait for ack_s==1, then go to RELEASE.
//    RELEASE: out_strobe=0, out_nib held. Wait for ack_s==0. If k==0, go to SETUP with k=1; else go to IDLE.
//  - Nibble order: MSB_FIRST=1 sends in_data[7:4] then [3:0]. MSB_FIRST=0 sends the reverse.
//  - Timeout counter: cleared on entry to STROBE and to RELEASE. Counts each clock spent in those states.
//    If it reaches TIMEOUT_CYCLES: out_strobe=0, out_timeout=1, go to IDLE, and drop the remaining nibble.
//  - Simultaneous ack edge and timeout expiry: the ack wins and no timeout is flagged.
//  - Minimum per-byte latency, accept to IDLE, with ack returned immediately:
//    2*(SETUP_CYCLES + 2*(2 sync + 1)) clocks.
//  - out_nib holds its last value in IDLE. It changes only on entry to SETUP.
//  - Reset asserted mid-transfer: all outputs go to reset values immediately. The byte is dropped.
//  - Counter widths are $clog2(max(SETUP_CYCLES, TIMEOUT_CYCLES)+1). No wrap: counters saturate at the limit.
// STRUCTURE
//  - Shared header rpi_if_defs.vh: state encodings (IDLE/SETUP/STROBE/RELEASE) and the nibble width, 4.
//    The Pi->FPGA input path uses the same header.
//  - Sub-module sync_2ff (1-bit, async active-high reset to 0) for in_ack. It is reused for other Pi inputs.
//  - This file contains the FSM, setup/timeout counters, byte and nibble-index registers, and output registers.
// TESTING
//  1. Hold in_rst=1 with random in_valid/in_ack -> strobe=0, nib=0, ready=0, busy=0, timeout=0.
//     After release with in_ack=0 -> ready=1 within 3 clocks.
//  2. Send 0xA5 with MSB_FIRST=1; Pi model acks 3 clocks after strobe and releases 3 clocks after it drops.
//     -> strobe pulses with nib=0xA, then nib=0x5, each stable >=SETUP_CYCLES before strobe; then ready=1.
//  3. Same as 2 with MSB_FIRST=0 -> Pi receives 0x5 then 0xA.
//  4. in_valid held with 0x12 then 0x34 back-to-back -> Pi sees 1,2,3,4 in order; no byte lost or duplicated.
//  5. Pi never acks -> strobe falls after TIMEOUT_CYCLES, timeout=1, busy=0.
//     Next accepted byte 0x77 clears timeout and transfers normally.
//  6. in_ack stuck at 1 in IDLE -> ready stays 0, no strobe. Assert in_rst during STROBE of the high nibble
//     -> strobe=0 the same cycle; after release 0xC3 transfers correctly.

Source files
------------

// File: rtl/rpi_nibble_tx_pkg.sv
// Shared definitions for the Pi GPIO nibble links: transfer FSM states,
// nibble width and the nibble-order helper.
package rpi_nibble_tx_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 2 * NIB_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Nibble k of a byte in wire order; k=0 goes out first.
  function automatic logic [NIB_W-1:0] nib_sel(input logic [BYTE_W-1:0] b,
                                               input logic               idx,
                                               input bit                 msb_first);
    return ((idx == 1'b0) == msb_first) ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/rpi_nibble_tx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous Pi input; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rpi_nibble_tx.sv
// FPGA->Pi byte return path: each byte leaves as two nibbles on GPIO using a
// 4-phase strobe/ack handshake, with setup hold-off and ack timeout.
module rpi_nibble_tx
  import rpi_nibble_tx_pkg::*;
#(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic              in_ack,
  output logic [NIB_W-1:0]  out_nib,
  output logic              out_strobe,
  output logic              out_busy,
  output logic              out_timeout
);

  localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);

  logic ack_s;

  sync_2ff u_ack_sync (
    .clk_i (in_clk),
    .rst_i (in_rst),
    .d_i   (in_ack),
    .q_o   (ack_s)
  );

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                idx_q,     idx_d;
  logic [BYTE_W-1:0]   byte_q,    byte_d;
  logic [NIB_W-1:0]    nib_q,     nib_d;
  logic                strobe_q,  strobe_d;
  logic                ready_q,   ready_d;
  logic                busy_q,    busy_d;
  logic                timeout_q, timeout_d;
  logic                accept;
  logic [CNT_W-1:0]    cnt_inc;

  assign accept  = in_valid && ready_q;
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    nib_d     = nib_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          byte_d    = in_data;
          idx_d     = 1'b0;
          nib_d     = nib_sel(in_data, 1'b0, MSB_FIRST);
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STROBE: begin
        // An ack arriving on the expiry clock still counts as success.
        if (ack_s) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          if (idx_q == 1'b0) begin
            idx_d   = 1'b1;
            nib_d   = nib_sel(byte_q, 1'b1, MSB_FIRST);
            cnt_d   = '0;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A Pi still holding ack keeps new bytes out.
    ready_d  = (state_q == ST_IDLE) && !ack_s && !accept;
    strobe_d = (state_d == ST_STROBE);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 1'b0;
      byte_q    <= '0;
      nib_q     <= '0;
      strobe_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      nib_q     <= nib_d;
      strobe_q  <= strobe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_ready   = ready_q;
  assign out_nib     = nib_q;
  assign out_strobe  = strobe_q;
  assign out_busy    = busy_q;
  assign out_timeout = timeout_q;

endmodule

// File: tb/tb_rpi_nibble_tx.sv
// Directed bench for rpi_nibble_tx: one MSB-first and one LSB-first instance,
// each answered by a Pi handshake model.
module tb_rpi_nibble_tx;

  localparam int SETUP   = 4;
  localparam int TIMEOUT = 40;
  // Pi acks 3 clocks after strobe and releases 3 after it drops; with the
  // 2-flop synchronizer each strobe/release phase lasts 5 clocks.
  localparam int XFER_CLKS = 2 * (SETUP + 5 + 5);

  typedef enum {PI_NORMAL, PI_SILENT, PI_MANUAL} pi_mode_e;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [3:0] first;
    logic [3:0] second;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_w [2];
  logic [1:0] valid_w = '0;
  logic [1:0] ack_w   = '0;
  logic [1:0] ready_w, strobe_w, busy_w, timeout_w;
  logic [3:0] nib_w  [2];

  pi_mode_e   pi_mode [2];
  logic       force_ack = 1'b0;
  logic [3:0] rx_log    [2][32];
  int         setup_log [2][32];
  int         rx_cnt    [2];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rpi_nibble_tx #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TIMEOUT), .MSB_FIRST(1'b1)) dut_msb (
    .in_clk(clk), .in_rst(rst), .in_data(data_w[0]), .in_valid(valid_w[0]),
    .out_ready(ready_w[0]), .in_ack(ack_w[0]), .out_nib(nib_w[0]),
    .out_strobe(strobe_w[0]), .out_busy(busy_w[0]), .out_timeout(timeout_w[0])
  );

  rpi_nibble_tx #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TIMEOUT), .MSB_FIRST(1'b0)) dut_lsb (
    .in_clk(clk), .in_rst(rst), .in_data(data_w[1]), .in_valid(valid_w[1]),
    .out_ready(ready_w[1]), .in_ack(ack_w[1]), .out_nib(nib_w[1]),
    .out_strobe(strobe_w[1]), .out_busy(busy_w[1]), .out_timeout(timeout_w[1])
  );

  // Pi model: logs each nibble on strobe rise together with how long it was stable.
  initial begin : pi_model
    int         hi   [2];
    int         lo   [2];
    int         stab [2];
    logic       prev_s [2];
    logic [3:0] prev_n [2];
    for (int i = 0; i < 2; i++) begin
      hi[i] = 0; lo[i] = 0; stab[i] = 0; prev_s[i] = 1'b0; prev_n[i] = '0; rx_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (nib_w[i] == prev_n[i]) stab[i]++;
        else stab[i] = 0;
        prev_n[i] = nib_w[i];
        if (strobe_w[i] && !prev_s[i] && rx_cnt[i] < 32) begin
          rx_log[i][rx_cnt[i]]    = nib_w[i];
          setup_log[i][rx_cnt[i]] = stab[i];
          rx_cnt[i]++;
        end
        prev_s[i] = strobe_w[i];
        case (pi_mode[i])
          PI_MANUAL: ack_w[i] = force_ack;
          PI_SILENT: ack_w[i] = 1'b0;
          default: begin
            if (strobe_w[i]) begin
              lo[i] = 0;
              hi[i]++;
              if (hi[i] >= 3) ack_w[i] = 1'b1;
            end else begin
              hi[i] = 0;
              if (ack_w[i]) begin
                lo[i]++;
                if (lo[i] >= 3) begin
                  ack_w[i] = 1'b0;
                  lo[i]    = 0;
                end
              end
            end
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int i, input int which);
    case (which)
      0:       return busy_w[i];
      1:       return ready_w[i];
      default: return strobe_w[i];
    endcase
  endfunction

  // which: 0 busy, 1 ready, 2 strobe
  task automatic wait_for(input int i, input int which, input logic lvl,
                          input int max_clks, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_clks && !ok; c++) begin
      tick();
      if (get_sig(i, which) == lvl) ok = 1'b1;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, output int busy_clks, output bit accepted);
    bit done;
    data_w[i]  = d;
    valid_w[i] = 1'b1;
    busy_clks  = 0;
    wait_for(i, 0, 1'b1, 100, accepted);
    valid_w[i] = 1'b0;
    if (accepted) begin
      busy_clks = 1;
      done      = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
        tick();
        if (busy_w[i]) busy_clks++;
        else done = 1'b1;
      end
    end
  endtask

  task automatic check_pair(input string tag, input int i, input int base,
                            input logic [3:0] n0, input logic [3:0] n1);
    check({tag, " nibble count"}, 32'(rx_cnt[i] - base), 32'd2);
    check({tag, " nibble 0"}, 32'(rx_log[i][base]), 32'(n0));
    check({tag, " nibble 1"}, 32'(rx_log[i][base + 1]), 32'(n1));
    check({tag, " setup 0 held"}, 32'(setup_log[i][base] >= SETUP), 32'd1);
    check({tag, " setup 1 held"}, 32'(setup_log[i][base + 1] >= SETUP), 32'd1);
  endtask

  vec_t vecs [5];

  initial begin : main
    int  base;
    int  bc;
    bit  ok;
    bit  ok2;
    bit  activity;

    vecs[0] = '{inst: 0, data: 8'hA5, first: 4'hA, second: 4'h5};
    vecs[1] = '{inst: 1, data: 8'hA5, first: 4'h5, second: 4'hA};
    vecs[2] = '{inst: 0, data: 8'h3C, first: 4'h3, second: 4'hC};
    vecs[3] = '{inst: 1, data: 8'h81, first: 4'h1, second: 4'h8};
    vecs[4] = '{inst: 0, data: 8'hF0, first: 4'hF, second: 4'h0};

    data_w[0]  = '0;
    data_w[1]  = '0;
    pi_mode[0] = PI_MANUAL;
    pi_mode[1] = PI_MANUAL;

    // Reset held with random valid/ack: all outputs stay at reset values.
    for (int c = 0; c < 8; c++) begin
      tick();
      valid_w   = 2'($urandom_range(0, 3));
      force_ack = 1'($urandom_range(0, 1));
      data_w[0] = 8'($urandom);
      check("reset outputs msb", {strobe_w[0], nib_w[0], ready_w[0], busy_w[0], timeout_w[0]}, '0);
      check("reset outputs lsb", {strobe_w[1], nib_w[1], ready_w[1], busy_w[1], timeout_w[1]}, '0);
    end
    valid_w   = '0;
    force_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    wait_for(0, 1, 1'b1, 3, ok);
    check("ready after reset", 32'(ok), 32'd1);
    pi_mode[0] = PI_NORMAL;
    pi_mode[1] = PI_NORMAL;
    tick();

    // Single bytes through both nibble orders.
    for (int v = 0; v < 5; v++) begin
      base = rx_cnt[vecs[v].inst];
      send(vecs[v].inst, vecs[v].data, bc, ok);
      check($sformatf("vec%0d accepted", v), 32'(ok), 32'd1);
      check($sformatf("vec%0d busy clocks", v), 32'(bc), 32'(XFER_CLKS));
      check_pair($sformatf("vec%0d", v), vecs[v].inst, base, vecs[v].first, vecs[v].second);
      check($sformatf("vec%0d timeout", v), 32'(timeout_w[vecs[v].inst]), 32'd0);
      wait_for(vecs[v].inst, 1, 1'b1, 5, ok);
      check($sformatf("vec%0d ready back", v), 32'(ok), 32'd1);
    end

    // Back-to-back bytes with in_valid held throughout.
    base       = rx_cnt[0];
    data_w[0]  = 8'h12;
    valid_w[0] = 1'b1;
    wait_for(0, 0, 1'b1, 20, ok);
    data_w[0]  = 8'h34;
    wait_for(0, 0, 1'b0, 200, ok2);
    ok = ok & ok2;
    wait_for(0, 0, 1'b1, 20, ok2);
    ok = ok & ok2;
    valid_w[0] = 1'b0;
    wait_for(0, 0, 1'b0, 200, ok2);
    ok = ok & ok2;
    check("b2b handshake progressed", 32'(ok), 32'd1);
    wait_for(0, 1, 1'b1, 5, ok);
    check("b2b ready back", 32'(ok), 32'd1);
    check("b2b nibble count", 32'(rx_cnt[0] - base), 32'd4);
    check("b2b nibbles", {16'h0, rx_log[0][base], rx_log[0][base + 1],
                          rx_log[0][base + 2], rx_log[0][base + 3]}, 32'h1234);

    // Pi never acks: abort after TIMEOUT clocks of strobe, remaining nibble dropped.
    pi_mode[0] = PI_SILENT;
    base       = rx_cnt[0];
    send(0, 8'h9E, bc, ok);
    check("timeout accepted", 32'(ok), 32'd1);
    check("timeout busy clocks", 32'(bc), 32'(SETUP + TIMEOUT));
    check("timeout flag", {timeout_w[0], strobe_w[0], busy_w[0]}, 32'b100);
    check("timeout nibbles seen", 32'(rx_cnt[0] - base), 32'd1);
    check("timeout first nibble", 32'(rx_log[0][base]), 32'h9);
    pi_mode[0] = PI_NORMAL;
    wait_for(0, 1, 1'b1, 5, ok);
    check("timeout ready back", 32'(ok), 32'd1);
    base = rx_cnt[0];
    send(0, 8'h77, bc, ok);
    check("after timeout busy clocks", 32'(bc), 32'(XFER_CLKS));
    check("after timeout flag cleared", 32'(timeout_w[0]), 32'd0);
    check_pair("after timeout", 0, base, 4'h7, 4'h7);
    wait_for(0, 1, 1'b1, 5, ok);

    // Ack stuck high in IDLE blocks new bytes.
    pi_mode[0] = PI_MANUAL;
    force_ack  = 1'b1;
    repeat (4) tick();
    check("stuck ack ready low", 32'(ready_w[0]), 32'd0);
    data_w[0]  = 8'h55;
    valid_w[0] = 1'b1;
    activity   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (strobe_w[0] || busy_w[0] || ready_w[0]) activity = 1'b1;
    end
    check("stuck ack no transfer", 32'(activity), 32'd0);
    valid_w[0] = 1'b0;
    force_ack  = 1'b0;
    tick();
    pi_mode[0] = PI_NORMAL;
    wait_for(0, 1, 1'b1, 6, ok);
    check("stuck ack released ready", 32'(ok), 32'd1);

    // Reset during the high-nibble strobe, then a clean transfer.
    data_w[0]  = 8'hC3;
    valid_w[0] = 1'b1;
    wait_for(0, 2, 1'b1, 60, ok);
    check("reset test strobe seen", 32'(ok), 32'd1);
    check("reset test high nibble", 32'(nib_w[0]), 32'hC);
    rst        = 1'b1;
    valid_w[0] = 1'b0;
    #1;
    check("mid-transfer reset outputs",
          {strobe_w[0], nib_w[0], ready_w[0], busy_w[0], timeout_w[0]}, '0);
    repeat (3) tick();
    rst = 1'b0;
    wait_for(0, 1, 1'b1, 8, ok);
    check("ready after mid reset", 32'(ok), 32'd1);
    base = rx_cnt[0];
    send(0, 8'hC3, bc, ok);
    check("post reset busy clocks", 32'(bc), 32'(XFER_CLKS));
    check_pair("post reset", 0, base, 4'hC, 4'h3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
